cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares the single memory-side burst port between the instruction cache and the data cache. Serialises one full-line transaction at a time: iCache refill, dCache refill, or dCache dirty-line writeback. Routes the address/data handshakes to the granted cache and generates beat counts and `m_wlast`. Sits between both cache controllers and the AXI bridge.

## Interface
- `LINE_WORDS`, 8, beats per line burst; a power of 2, at least 2.
- `ADDR_W`, 32, address width.
- `clk  in  1  clock`; `reset  in  1  reset, synchronous, active-high`
- `i_req  in  1  iCache refill request, held until its last i_data_ok`
- `i_addr  in  ADDR_W  line-aligned refill address`
- `i_addr_ok  out  1  iCache address accepted (1-cycle pulse)`
- `i_data_ok  out  1  iCache read beat valid`
- `i_rdata  out  32  iCache read beat`
- `d_req  in  1  dCache request, held until its last d_data_ok`
- `d_wr  in  1  1 = writeback, 0 = refill; stable while d_req high`
- `d_addr  in  ADDR_W  line-aligned address`
- `d_wdata  in  32  writeback beat; dCache advances on d_data_ok`
- `d_addr_ok  out  1  dCache address accepted`
- `d_data_ok  out  1  dCache beat done (read valid / write consumed)`
- `d_rdata  out  32  dCache read beat`
- `m_req  out  1  memory address-phase request`
- `m_wr  out  1  write transaction`
- `m_addr  out  ADDR_W  registered burst address`
- `m_len  out  8  LINE_WORDS-1`
- `m_wdata  out  32  write beat`
- `m_wlast  out  1  final write beat`
- `m_addr_ok  in  1  address accepted`
- `m_data_ok  in  1  beat done`
- `m_rdata  in  32  read beat`

## Operation
- FSM states: IDLE, ADDR, DATA. Owner register: NONE, I, D. Beat counter width log2(LINE_WORDS). One-bit `last_i` round-robin flag.
- IDLE:
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both: grant the cache that did not own the previous transaction. After reset, D wins.
  - On grant, latch `m_addr` and `m_wr` from the winner (`m_wr` = 0 for I), clear beat = 0, go to ADDR.
- ADDR:
  - `m_req` = 1, held until `m_addr_ok`.
  - On `m_addr_ok`: pulse the owner's `*_addr_ok` in the same cycle, then go to DATA.
- DATA:
  - Each `m_data_ok` increments beat and pulses the owner's `*_data_ok` combinationally.
  - Reads: `*_rdata` = `m_rdata`.
  - Writes: `m_wdata` = `d_wdata`.
  - When `m_data_ok` arrives with beat == LINE_WORDS-1, return to IDLE. Owner becomes NONE and `last_i` is updated.
- `m_wlast` = DATA & `m_wr` & beat == LINE_WORDS-1.
- Non-owner `*_addr_ok`/`*_data_ok` are always 0. Non-owner requests stay pending and are never dropped.
- `i_rdata`/`d_rdata` are driven from `m_rdata` at all times; only the ok strobes qualify them.
- Write-after-read ordering within dCache is the dCache's responsibility: it issues the writeback, waits for completion, then issues the refill. The arbiter may interleave an iCache transaction between the two.
- Reset mid-transaction:
  - State → IDLE, owner NONE, beat 0, `last_i` 0.
  - All outputs 0, next cycle.
  - The memory side is reset in the same cycle by the same reset.

## Timing
- Reset values: `m_req`, `m_wr`, `m_wlast`, all `*_addr_ok`/`*_data_ok` are 0; `m_addr` is 0; `m_len` is constant.
- Request to `m_req`: 1 cycle (IDLE grant edge, then ADDR).
- Back-to-back: a pending request is granted in the IDLE cycle following the last beat. Turnaround is exactly 1 idle cycle.
- Memory guarantees the first `m_data_ok` comes at least 1 cycle after `m_addr_ok`. `m_data_ok` outside DATA is ignored.
- `m_data_ok` may be asserted on consecutive cycles (one beat per cycle maximum).
- Requests dropped while in ADDR/DATA are a protocol error and are not supported. The arbiter does not abort.
- `m_addr`/`m_wr` are stable from ADDR entry through the last beat.

## Structure
- Shared package `cache_arb_pkg`: `arb_state_t` {IDLE, ADDR, DATA}, `arb_owner_t` {NONE, I, D}, and a `LINE_BEAT_W` localparam function.
- Sub-module `rr_arbiter2`: 2-requester round-robin picker. Inputs: `req[1:0]`, `last`. Output: `grant[1:0]`. Purely combinational.
- FSM, beat counter and muxing live in the top.

## Test plan
- i_req only, addr 0x1000_0020, `m_addr_ok` on cycle 3, 8 consecutive `m_data_ok` with rdata 0..7 → `i_addr_ok` pulses once; `i_data_ok` pulses 8× with `i_rdata` 0..7; `d_*_ok` stay 0; IDLE after beat 7.
- d_req with d_wr=1, addr 0x2000_0040, `m_data_ok` gapped (every other cycle) → `m_wr`=1; `m_wlast` high only during beat 7; `m_wdata` tracks `d_wdata`; 8 `d_data_ok` pulses.
- i_req and d_req asserted together from reset → D granted first; I granted in the IDLE cycle after D's last beat; next simultaneous pair → D wins again because I was last.
- `m_addr_ok` delayed 5 cycles → `m_req` held high and `m_addr` unchanged for all 5 cycles; no `*_data_ok` before `m_addr_ok`.
- reset asserted at beat 3 of a dCache refill → next cycle all outputs 0 and state IDLE; after release, a pending i_req is granted with beat restarting at 0.
- spurious `m_data_ok` in IDLE/ADDR → no `*_data_ok` pulse and beat count unchanged.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM states, bus owner
// encoding and the beat-counter width helper.
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      I    = 2'd1,
      D    = 2'd2
   } arb_owner_t;

   // Width of a counter that indexes every beat of a line burst.
   function automatic int line_beat_w(input int words);
      if (words > 1) begin
         return $clog2(words);
      end else begin
         return 1;
      end
   endfunction

   localparam int LINE_BEAT_W = line_beat_w(8);

endpackage

// File: rtl/cache_mem_arbiter_rr.sv
// Two-requester round-robin picker. Requester 0 is the iCache, requester 1
// the dCache. 'last' = 1 means requester 1 was served last, so a tie goes to
// requester 0; 'last' = 0 hands a tie to requester 1.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   // Pick at most one requester; ties alternate on 'last'.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01: grant = 2'b01;
         2'b10: grant = 2'b10;
         2'b11: begin
            if (last) begin
               grant = 2'b01;
            end else begin
               grant = 2'b10;
            end
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single memory burst port between the iCache and dCache. One
// full-line transaction at a time; address and data handshakes are routed
// to the current owner, and the beat counter produces m_wlast.
module cache_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_addr_ok,
   output logic              i_data_ok,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_addr_ok,
   output logic              d_data_ok,
   output logic [31:0]       d_rdata,
   output logic              m_req,
   output logic              m_wr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [7:0]        m_len,
   output logic [31:0]       m_wdata,
   output logic              m_wlast,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [31:0]       m_rdata
);

   localparam int                BEAT_W    = line_beat_w(LINE_WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   arb_state_t        state_r;
   arb_owner_t        owner_r;
   logic [BEAT_W-1:0] beat_r;
   // Tie-break pointer: set when the dCache finishes (iCache gets the next
   // tie), cleared when the iCache finishes or on reset (dCache gets it).
   logic              last_i_r;
   logic [1:0]        grant_s;

   rr_arbiter2 u_rr (
      .req   ({d_req, i_req}),
      .last  (last_i_r),
      .grant (grant_s)
   );

   // Transaction FSM: grant, address phase, then count beats to the line end.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         owner_r  <= NONE;
         beat_r   <= {BEAT_W{1'b0}};
         last_i_r <= 1'b0;
         m_addr   <= {ADDR_W{1'b0}};
         m_wr     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_s[1]) begin
                  owner_r <= D;
                  m_addr  <= d_addr;
                  m_wr    <= d_wr;
                  beat_r  <= {BEAT_W{1'b0}};
                  state_r <= ADDR;
               end else if (grant_s[0]) begin
                  owner_r <= I;
                  m_addr  <= i_addr;
                  m_wr    <= 1'b0;
                  beat_r  <= {BEAT_W{1'b0}};
                  state_r <= ADDR;
               end else begin
                  state_r <= IDLE;
               end
            end
            ADDR: begin
               if (m_addr_ok) begin
                  state_r <= DATA;
               end else begin
                  state_r <= ADDR;
               end
            end
            DATA: begin
               if (m_data_ok) begin
                  if (beat_r == LAST_BEAT) begin
                     state_r  <= IDLE;
                     owner_r  <= NONE;
                     beat_r   <= {BEAT_W{1'b0}};
                     last_i_r <= (owner_r == D);
                  end else begin
                     beat_r <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  state_r <= DATA;
               end
            end
            default: begin
               state_r <= IDLE;
               owner_r <= NONE;
               beat_r  <= {BEAT_W{1'b0}};
            end
         endcase
      end
   end

   // Route handshakes to the owner only; memory strobes outside their phase are ignored.
   always_comb begin
      m_req     = (state_r == ADDR);
      i_addr_ok = (state_r == ADDR) && m_addr_ok && (owner_r == I);
      d_addr_ok = (state_r == ADDR) && m_addr_ok && (owner_r == D);
      i_data_ok = (state_r == DATA) && m_data_ok && (owner_r == I);
      d_data_ok = (state_r == DATA) && m_data_ok && (owner_r == D);
      m_wlast   = (state_r == DATA) && m_wr && (beat_r == LAST_BEAT);
      if ((state_r == DATA) && m_wr) begin
         m_wdata = d_wdata;
      end else begin
         m_wdata = 32'h0000_0000;
      end
   end

   assign m_len   = 8'(LINE_WORDS - 1);
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: each scenario task drives the
// caches and memory side; expected data beats go into a scoreboard queue
// that a negedge monitor pops whenever an *_data_ok strobe appears.
module tb_cache_mem_arbiter;

   localparam int LW = 8;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, i_addr_ok, i_data_ok;
   logic [AW-1:0] i_addr;
   logic [31:0]   i_rdata;
   logic          d_req, d_wr, d_addr_ok, d_data_ok;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata, d_rdata;
   logic          m_req, m_wr, m_wlast, m_addr_ok, m_data_ok;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_len;
   logic [31:0]   m_wdata, m_rdata;

   typedef struct {
      logic        is_d;
      logic        wr;
      logic [31:0] rdata;
      logic [31:0] wdata;
      logic        wlast;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   i_aok_cnt = 0;
   int   d_aok_cnt = 0;

   cache_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
      .i_data_ok(i_data_ok), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_len(m_len),
      .m_wdata(m_wdata), .m_wlast(m_wlast),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every data strobe must match the oldest expected beat.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] rd;
      if (i_addr_ok) i_aok_cnt++;
      if (d_addr_ok) d_aok_cnt++;
      if (i_data_ok || d_data_ok) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got i_data_ok=%b d_data_ok=%b expected no strobe", i_data_ok, d_data_ok);
         end else begin
            e = exp_q.pop_front();
            if ({d_data_ok, i_data_ok} !== (e.is_d ? 2'b10 : 2'b01)) begin
               n_fail++;
               $display("FAIL beat_owner: got {d,i}_data_ok=%b%b expected is_d=%b", d_data_ok, i_data_ok, e.is_d);
            end
            if (!e.wr) begin
               rd = e.is_d ? d_rdata : i_rdata;
               n_checks++;
               if (rd !== e.rdata) begin
                  n_fail++;
                  $display("FAIL beat_rdata: got %h expected %h", rd, e.rdata);
               end
            end else begin
               n_checks++;
               if (m_wdata !== e.wdata) begin
                  n_fail++;
                  $display("FAIL beat_wdata: got %h expected %h", m_wdata, e.wdata);
               end
            end
            n_checks++;
            if (m_wlast !== e.wlast) begin
               n_fail++;
               $display("FAIL beat_wlast: got %b expected %b", m_wlast, e.wlast);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_wr = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0; m_addr_ok = 1'b0;
      m_data_ok = 1'b0; m_rdata = 32'h0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Memory address phase: m_addr_ok after 'delay' waiting cycles.
   task automatic addr_phase(input int delay);
      for (int c = 0; c <= delay; c++) begin
         m_addr_ok = (c == delay);
         tick();
      end
      m_addr_ok = 1'b0;
   endtask

   // Memory data phase: LW beats, 'gap' idle cycles before each beat.
   task automatic data_phase(input logic is_d, input logic wr, input logic [31:0] base, input int gap);
      exp_t e;
      for (int k = 0; k < LW; k++) begin
         if (wr) d_wdata = base + 32'(k);
         for (int g = 0; g < gap; g++) begin
            m_data_ok = 1'b0;
            tick();
         end
         m_data_ok = 1'b1;
         m_rdata   = wr ? (32'hDEAD_0000 + 32'(k)) : (base + 32'(k));
         e.is_d  = is_d;
         e.wr    = wr;
         e.rdata = m_rdata;
         e.wdata = wr ? d_wdata : 32'h0;
         e.wlast = wr && (k == LW - 1);
         exp_q.push_back(e);
         tick();
      end
      m_data_ok = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      #3;
      n_checks++;
      if ({m_req, m_wr, m_wlast} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got req/wr/wlast=%b expected 000", {m_req, m_wr, m_wlast});
      end
      n_checks++;
      if ({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_oks: got %b expected 0000", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok});
      end
      n_checks++;
      if (m_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_m_addr: got %h expected 00000000", m_addr);
      end
      n_checks++;
      if (m_len !== 8'd7) begin
         n_fail++;
         $display("FAIL reset_m_len: got %0d expected 7", m_len);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_i_refill;
      i_aok_cnt = 0; d_aok_cnt = 0;
      i_req = 1'b1; i_addr = 32'h1000_0020;
      tick();
      for (int c = 0; c < 3; c++) begin
         m_addr_ok = (c == 2);
         #3;
         n_checks++;
         if ({m_req, m_wr, m_addr} !== {1'b1, 1'b0, 32'h1000_0020}) begin
            n_fail++;
            $display("FAIL i_addr_phase: got req=%b wr=%b addr=%h expected 1 0 10000020", m_req, m_wr, m_addr);
         end
         tick();
      end
      m_addr_ok = 1'b0;
      data_phase(1'b0, 1'b0, 32'h0, 0);
      i_req = 1'b0;
      #3;
      n_checks++;
      if (m_req !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL i_refill_end: got m_req=%b pending=%0d expected 0 0", m_req, exp_q.size());
      end
      tick();
      tick();
      n_checks++;
      if ({i_aok_cnt, d_aok_cnt} !== {32'd1, 32'd0} || m_req !== 1'b0) begin
         n_fail++;
         $display("FAIL i_refill_aok: got i=%0d d=%0d m_req=%b expected 1 0 0", i_aok_cnt, d_aok_cnt, m_req);
      end
   endtask

   task automatic test_d_writeback;
      exp_t e;
      i_aok_cnt = 0; d_aok_cnt = 0;
      d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h2000_0040;
      tick();
      #3;
      n_checks++;
      if ({m_req, m_wr, m_addr} !== {1'b1, 1'b1, 32'h2000_0040}) begin
         n_fail++;
         $display("FAIL d_wb_grant: got req=%b wr=%b addr=%h expected 1 1 20000040", m_req, m_wr, m_addr);
      end
      addr_phase(0);
      for (int k = 0; k < LW; k++) begin
         d_wdata = 32'hA5A5_0000 + 32'(k);
         for (int g = 0; g < 2; g++) begin
            m_data_ok = (g == 1);
            if (g == 1) begin
               e.is_d = 1'b1; e.wr = 1'b1; e.rdata = 32'h0;
               e.wdata = d_wdata; e.wlast = (k == LW - 1);
               exp_q.push_back(e);
            end
            #3;
            n_checks++;
            if (m_wlast !== (k == LW - 1)) begin
               n_fail++;
               $display("FAIL d_wb_wlast: beat %0d got %b expected %b", k, m_wlast, (k == LW - 1));
            end
            n_checks++;
            if (m_wdata !== 32'hA5A5_0000 + 32'(k)) begin
               n_fail++;
               $display("FAIL d_wb_wdata: beat %0d got %h expected %h", k, m_wdata, 32'hA5A5_0000 + 32'(k));
            end
            tick();
         end
      end
      m_data_ok = 1'b0;
      d_req = 1'b0;
      #3;
      n_checks++;
      if ({m_req, m_wlast} !== 2'b00 || exp_q.size() != 0 || {d_aok_cnt, i_aok_cnt} !== {32'd1, 32'd0}) begin
         n_fail++;
         $display("FAIL d_wb_end: got req=%b wlast=%b pending=%0d daok=%0d iaok=%0d expected 0 0 0 1 0",
                  m_req, m_wlast, exp_q.size(), d_aok_cnt, i_aok_cnt);
      end
      tick();
   endtask

   task automatic test_simultaneous;
      do_reset();
      i_req = 1'b1; i_addr = 32'h1100_0000;
      d_req = 1'b1; d_addr = 32'h2200_0000; d_wr = 1'b0;
      tick();
      #3;
      n_checks++;
      if (m_addr !== 32'h2200_0000) begin
         n_fail++;
         $display("FAIL rr_first_d: got m_addr=%h expected 22000000", m_addr);
      end
      addr_phase(0);
      data_phase(1'b1, 1'b0, 32'h0000_0100, 0);
      d_req = 1'b0;
      #3;
      n_checks++;
      if (m_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_turnaround: got m_req=%b expected 0", m_req);
      end
      tick();
      #3;
      n_checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h1100_0000}) begin
         n_fail++;
         $display("FAIL rr_then_i: got req=%b addr=%h expected 1 11000000", m_req, m_addr);
      end
      addr_phase(1);
      data_phase(1'b0, 1'b0, 32'h0000_0200, 0);
      i_addr = 32'h1100_0040;
      d_req = 1'b1; d_addr = 32'h2200_0040;
      tick();
      #3;
      n_checks++;
      if (m_addr !== 32'h2200_0040) begin
         n_fail++;
         $display("FAIL rr_second_d: got m_addr=%h expected 22000040", m_addr);
      end
      addr_phase(0);
      data_phase(1'b1, 1'b0, 32'h0000_0300, 1);
      d_req = 1'b0;
      tick();
      #3;
      n_checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h1100_0040}) begin
         n_fail++;
         $display("FAIL rr_pending_i: got req=%b addr=%h expected 1 11000040", m_req, m_addr);
      end
      addr_phase(0);
      data_phase(1'b0, 1'b0, 32'h0000_0400, 0);
      i_req = 1'b0;
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rr_drain: got pending=%0d expected 0", exp_q.size());
      end
      tick();
   endtask

   task automatic test_addr_delay;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h3000_0080;
      tick();
      for (int c = 0; c <= 5; c++) begin
         m_addr_ok = (c == 5);
         #3;
         n_checks++;
         if ({m_req, m_addr} !== {1'b1, 32'h3000_0080}) begin
            n_fail++;
            $display("FAIL addr_hold: cycle %0d got req=%b addr=%h expected 1 30000080", c, m_req, m_addr);
         end
         tick();
      end
      m_addr_ok = 1'b0;
      data_phase(1'b1, 1'b0, 32'h0000_0500, 0);
      d_req = 1'b0;
      #3;
      n_checks++;
      if (m_req !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL addr_delay_end: got m_req=%b pending=%0d expected 0 0", m_req, exp_q.size());
      end
      tick();
   endtask

   task automatic test_reset_mid;
      exp_t e;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h4000_0000;
      tick();
      addr_phase(0);
      for (int k = 0; k < 3; k++) begin
         m_data_ok = 1'b1;
         m_rdata = 32'h0000_0700 + 32'(k);
         e.is_d = 1'b1; e.wr = 1'b0; e.rdata = m_rdata; e.wdata = 32'h0; e.wlast = 1'b0;
         exp_q.push_back(e);
         tick();
      end
      reset = 1'b1;
      m_data_ok = 1'b0;
      d_req = 1'b0;
      i_req = 1'b1; i_addr = 32'h5000_0000;
      tick();
      #3;
      n_checks++;
      if ({m_req, m_wr, m_wlast, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 7'b0 ||
          m_addr !== 32'h0 || m_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got ctrl=%b addr=%h wdata=%h expected 0 0 0",
                  {m_req, m_wr, m_wlast, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, m_addr, m_wdata);
      end
      reset = 1'b0;
      tick();
      #3;
      n_checks++;
      if ({m_req, m_wr, m_addr} !== {1'b1, 1'b0, 32'h5000_0000}) begin
         n_fail++;
         $display("FAIL mid_reset_regrant: got req=%b wr=%b addr=%h expected 1 0 50000000", m_req, m_wr, m_addr);
      end
      addr_phase(0);
      data_phase(1'b0, 1'b0, 32'h0000_0800, 0);
      i_req = 1'b0;
      #3;
      n_checks++;
      if (m_req !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_reset_end: got m_req=%b pending=%0d expected 0 0", m_req, exp_q.size());
      end
      tick();
   endtask

   task automatic test_spurious;
      m_data_ok = 1'b1; m_rdata = 32'hBAD0_0000;
      tick();
      tick();
      d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h6000_0000;
      tick();
      for (int c = 0; c <= 2; c++) begin
         m_addr_ok = (c == 2);
         m_data_ok = (c < 2);
         tick();
      end
      m_addr_ok = 1'b0;
      data_phase(1'b1, 1'b1, 32'h0000_0900, 0);
      d_req = 1'b0;
      #3;
      n_checks++;
      if ({m_req, m_wlast} !== 2'b00 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL spurious_end: got req=%b wlast=%b pending=%0d expected 0 0 0", m_req, m_wlast, exp_q.size());
      end
      tick();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_i_refill();
      test_d_writeback();
      test_simultaneous();
      test_addr_delay();
      test_reset_mid();
      test_spurious();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
